id_inst_queue: RTL and testbench

Parametrised replacement for the IF/ID pipeline register. It is a DEPTH-entry in-order instruction queue between fetch and decode, with valid/ready handshakes on both sides. Each entry carries PC, instruction, exception tag and bad-vaddr. The block also generates the delay-slot flag, squashes wrong-path entries on a taken branch or jump while keeping the delay slot, and flushes completely on an exception or eret.

---
 rtl/id_pkg.sv | 25 ++
 rtl/id_inst_queue_storage.sv | 26 ++
 rtl/id_inst_queue.sv | 105 ++++++++++
 tb/tb_id_inst_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared widths, entry layout and sizing helpers for the decode-side instruction queue.
package id_pkg;

  localparam int ID_PC_W    = 32;
  localparam int ID_INST_W  = 32;
  localparam int ID_TAG_W   = 8;
  localparam int ID_ENTRY_W = ID_PC_W + ID_INST_W + ID_TAG_W + ID_PC_W;

  typedef struct packed {
    logic [ID_PC_W-1:0]   pc;
    logic [ID_INST_W-1:0] inst;
    logic [ID_TAG_W-1:0]  tag;
    logic [ID_PC_W-1:0]   badvaddr;
  } id_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a full queue (count == depth) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/id_inst_queue_storage.sv
// Entry array for the instruction queue: one synchronous write port, one asynchronous read port.
module iq_storage
  import id_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ID_ENTRY_W
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [W-1:0]            wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [W-1:0]            rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; validity lives in the pointers and count, so
  // clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/id_inst_queue.sv
// In-order fetch-to-decode instruction queue with delay-slot tracking, branch squash and flush.
module id_inst_queue
  import id_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = ID_PC_W,
  parameter int INST_W = ID_INST_W,
  parameter int TAG_W  = ID_TAG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_valid_i,
  input  logic [PC_W-1:0]         if_pc_i,
  input  logic [INST_W-1:0]       if_inst_i,
  input  logic [TAG_W-1:0]        if_tag_i,
  input  logic [PC_W-1:0]         if_badvaddr_i,
  output logic                    if_ready_o,
  output logic                    id_valid_o,
  output logic [PC_W-1:0]         id_pc_o,
  output logic [INST_W-1:0]       id_inst_o,
  output logic [TAG_W-1:0]        id_tag_o,
  output logic [PC_W-1:0]         id_badvaddr_o,
  output logic                    id_delayslot_o,
  input  logic                    id_ready_i,
  input  logic                    id_is_branch_i,
  input  logic                    redirect_i,
  input  logic                    flush_i,
  output logic [cnt_w(DEPTH)-1:0] count_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [TAG_W-1:0]  tag;
    logic [PC_W-1:0]   badvaddr;
  } entry_t;

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          ds_pending;
  logic          push, pop, squash, wr_en;
  entry_t        wr_entry, rd_entry;

  assign if_ready_o = (count != CW'(DEPTH));
  assign id_valid_o = (count != '0);
  assign push       = if_valid_i & if_ready_o;
  assign pop        = id_valid_o & id_ready_i;
  // A taken branch with an entry behind it keeps only that entry (the delay slot).
  assign squash     = pop & id_is_branch_i & redirect_i & (count > CW'(1));
  assign wr_en      = push & ~rst & ~flush_i & ~squash;
  assign count_o    = count;

  assign wr_entry = '{pc: if_pc_i, inst: if_inst_i, tag: if_tag_i, badvaddr: if_badvaddr_i};

  iq_storage #(.DEPTH(DEPTH), .W($bits(entry_t))) u_storage (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      ds_pending <= 1'b0;
    end else begin
      if (squash) begin
        rd_ptr <= rd_ptr + PW'(1);
        wr_ptr <= rd_ptr + PW'(2);
        count  <= CW'(1);
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      if (pop) ds_pending <= id_is_branch_i;
    end
  end

  // NOTE: every output gets a default before the conditional so no latch is inferred.
  always_comb begin
    id_pc_o        = '0;
    id_inst_o      = '0;
    id_tag_o       = '0;
    id_badvaddr_o  = '0;
    id_delayslot_o = 1'b0;
    if (id_valid_o) begin
      id_pc_o        = rd_entry.pc;
      id_inst_o      = rd_entry.inst;
      id_tag_o       = rd_entry.tag;
      id_badvaddr_o  = rd_entry.badvaddr;
      id_delayslot_o = ds_pending;
    end
  end

endmodule

// File: tb/tb_id_inst_queue.sv
// Self-checking bench for id_inst_queue: directed vector table plus randomized run against a queue model.
module tb_id_inst_queue;
  import id_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, if_valid_i, id_ready_i, id_is_branch_i, redirect_i, flush_i;
  logic [31:0] if_pc_i, if_inst_i, if_badvaddr_i;
  logic [7:0]  if_tag_i;
  logic        if_ready_o, id_valid_o, id_delayslot_o;
  logic [31:0] id_pc_o, id_inst_o, id_badvaddr_o;
  logic [7:0]  id_tag_o;
  logic [2:0]  count_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
    .if_tag_i(if_tag_i), .if_badvaddr_i(if_badvaddr_i), .if_ready_o(if_ready_o),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .id_tag_o(id_tag_o), .id_badvaddr_o(id_badvaddr_o), .id_delayslot_o(id_delayslot_o),
    .id_ready_i(id_ready_i), .id_is_branch_i(id_is_branch_i), .redirect_i(redirect_i),
    .flush_i(flush_i), .count_o(count_o)
  );

  typedef struct {
    string       name;
    logic        v, rdy, br, rd, fl, rs;
    logic [31:0] pc;
    logic [31:0] e_pc;
    logic        e_ds;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  // Payload fields are derived from the PC so every field of an entry is distinguishable.
  function automatic id_entry_t mk(input logic [31:0] pc);
    id_entry_t e;
    e.pc       = pc;
    e.inst     = pc ^ 32'hA5A5_0000;
    e.tag      = pc[9:2];
    e.badvaddr = pc + 32'd1;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic v, input logic [31:0] pc,
                     input logic rdy, input logic br, input logic rd, input logic fl,
                     input logic rs, input logic [31:0] e_pc, input logic e_ds, input int e_cnt);
    vec_t t;
    t.name = name; t.v = v; t.pc = pc; t.rdy = rdy; t.br = br; t.rd = rd;
    t.fl = fl; t.rs = rs; t.e_pc = e_pc; t.e_ds = e_ds; t.e_cnt = e_cnt;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy,
                       input logic br, input logic rd, input logic fl, input logic rs);
    id_entry_t e;
    e = mk(pc);
    if_valid_i = v; if_pc_i = pc; if_inst_i = e.inst; if_tag_i = e.tag;
    if_badvaddr_i = e.badvaddr; id_ready_i = rdy; id_is_branch_i = br;
    redirect_i = rd; flush_i = fl; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string name, input int cnt,
                               input logic [31:0] pc, input logic ds);
    id_entry_t e;
    e = (cnt != 0) ? mk(pc) : '0;
    check({name, ".count"},    64'(count_o),        64'(cnt));
    check({name, ".valid"},    64'(id_valid_o),     64'(cnt != 0));
    check({name, ".ready"},    64'(if_ready_o),     64'(cnt != DEPTH));
    check({name, ".pc"},       64'(id_pc_o),        64'(e.pc));
    check({name, ".inst"},     64'(id_inst_o),      64'(e.inst));
    check({name, ".tag"},      64'(id_tag_o),       64'(e.tag));
    check({name, ".badvaddr"}, 64'(id_badvaddr_o),  64'(e.badvaddr));
    check({name, ".ds"},       64'(id_delayslot_o), 64'((cnt != 0) && ds));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Randomized-phase reference model: a plain queue of entries plus the delay-slot flag.
  id_entry_t m_q[$];
  logic      m_ds;

  initial begin
    //                 name       v  pc          rdy br rd fl rs  e_pc        ds cnt
    add("reset",       0, 0,          0, 0, 0, 0, 1, 0,          0, 0);
    add("fill0",       1, 32'h100,    0, 0, 0, 0, 0, 32'h100,    0, 1);
    add("fill1",       1, 32'h104,    0, 0, 0, 0, 0, 32'h100,    0, 2);
    add("fill2",       1, 32'h108,    0, 0, 0, 0, 0, 32'h100,    0, 3);
    add("fill3",       1, 32'h10C,    0, 0, 0, 0, 0, 32'h100,    0, 4);
    add("full_push",   1, 32'h999,    0, 0, 0, 0, 0, 32'h100,    0, 4);
    add("drain0",      0, 0,          1, 0, 0, 0, 0, 32'h104,    0, 3);
    add("drain1",      0, 0,          1, 0, 0, 0, 0, 32'h108,    0, 2);
    add("drain2",      0, 0,          1, 0, 0, 0, 0, 32'h10C,    0, 1);
    add("drain3",      0, 0,          1, 0, 0, 0, 0, 0,          0, 0);
    add("empty_pop",   0, 0,          1, 0, 0, 0, 0, 0,          0, 0);
    add("wrap_pre0",   1, 32'h600,    0, 0, 0, 0, 0, 32'h600,    0, 1);
    add("wrap_pre1",   1, 32'h604,    0, 0, 0, 0, 0, 32'h600,    0, 2);
    for (int k = 0; k < 10; k++)
      add($sformatf("wrap%0d", k), 1, 32'h608 + 32'(4*k), 1, 0, 0, 0, 0,
          32'h604 + 32'(4*k), 0, 2);
    add("wrap_drain0", 0, 0,          1, 0, 0, 0, 0, 32'h62C,    0, 1);
    add("wrap_drain1", 0, 0,          1, 0, 0, 0, 0, 0,          0, 0);
    add("rq_fill0",    1, 32'h200,    0, 0, 0, 0, 0, 32'h200,    0, 1);
    add("rq_fill1",    1, 32'h204,    0, 0, 0, 0, 0, 32'h200,    0, 2);
    add("rq_fill2",    1, 32'h208,    0, 0, 0, 0, 0, 32'h200,    0, 3);
    add("rq_fill3",    1, 32'h20C,    0, 0, 0, 0, 0, 32'h200,    0, 4);
    add("rq_redirect", 0, 0,          1, 1, 1, 0, 0, 32'h204,    1, 1);
    add("rq_newpath",  1, 32'h400,    0, 0, 0, 0, 0, 32'h204,    1, 2);
    add("rq_pop_ds",   0, 0,          1, 0, 0, 0, 0, 32'h400,    0, 1);
    add("rq_pop_new",  0, 0,          1, 0, 0, 0, 0, 0,          0, 0);
    add("rp_fill0",    1, 32'h210,    0, 0, 0, 0, 0, 32'h210,    0, 1);
    add("rp_fill1",    1, 32'h214,    0, 0, 0, 0, 0, 32'h210,    0, 2);
    add("rp_fill2",    1, 32'h218,    0, 0, 0, 0, 0, 32'h210,    0, 3);
    add("rp_redir_push", 1, 32'h21C,  1, 1, 1, 0, 0, 32'h214,    1, 1);
    add("rp_pop",      0, 0,          1, 0, 0, 0, 0, 0,          0, 0);
    add("rn_fill",     1, 32'h300,    0, 0, 0, 0, 0, 32'h300,    0, 1);
    add("rn_redirect", 0, 0,          1, 1, 1, 0, 0, 0,          0, 0);
    add("rn_ds_push",  1, 32'h304,    0, 0, 0, 0, 0, 32'h304,    1, 1);
    add("rn_new_push", 1, 32'h500,    1, 0, 0, 0, 0, 32'h500,    0, 1);
    add("rn_pop",      0, 0,          1, 0, 0, 0, 0, 0,          0, 0);
    add("rs_fill",     1, 32'h310,    0, 0, 0, 0, 0, 32'h310,    0, 1);
    add("rs_redir_push", 1, 32'h314,  1, 1, 1, 0, 0, 32'h314,    1, 1);
    add("rs_pop",      0, 0,          1, 0, 0, 0, 0, 0,          0, 0);
    add("ig_fill0",    1, 32'hB00,    0, 0, 0, 0, 0, 32'hB00,    0, 1);
    add("ig_fill1",    1, 32'hB04,    0, 0, 0, 0, 0, 32'hB00,    0, 2);
    add("ig_fill2",    1, 32'hB08,    0, 0, 0, 0, 0, 32'hB00,    0, 3);
    add("ig_no_br",    0, 0,          1, 0, 1, 0, 0, 32'hB04,    0, 2);
    add("ig_no_pop",   0, 0,          0, 1, 1, 0, 0, 32'hB04,    0, 2);
    add("ig_pop0",     0, 0,          1, 0, 0, 0, 0, 32'hB08,    0, 1);
    add("ig_pop1",     0, 0,          1, 0, 0, 0, 0, 0,          0, 0);
    add("fl_fill0",    1, 32'h700,    0, 0, 0, 0, 0, 32'h700,    0, 1);
    add("fl_fill1",    1, 32'h704,    0, 0, 0, 0, 0, 32'h700,    0, 2);
    add("fl_fill2",    1, 32'h708,    0, 0, 0, 0, 0, 32'h700,    0, 3);
    add("fl_fill3",    1, 32'h70C,    0, 0, 0, 0, 0, 32'h700,    0, 4);
    add("fl_flush",    1, 32'h7F0,    0, 0, 0, 1, 0, 0,          0, 0);
    add("fl_after",    0, 0,          0, 0, 0, 0, 0, 0,          0, 0);
    add("mr_fill0",    1, 32'h800,    0, 0, 0, 0, 0, 32'h800,    0, 1);
    add("mr_fill1",    1, 32'h804,    0, 0, 0, 0, 0, 32'h800,    0, 2);
    add("mr_branch",   1, 32'h808,    1, 1, 0, 0, 0, 32'h804,    1, 2);
    add("mr_reset",    1, 32'h80C,    1, 0, 0, 0, 1, 0,          0, 0);
    add("mr_push",     1, 32'h900,    0, 0, 0, 0, 0, 32'h900,    0, 1);
    add("mr_pop",      0, 0,          1, 0, 0, 0, 0, 0,          0, 0);
    add("fr_fill0",    1, 32'hA00,    0, 0, 0, 0, 0, 32'hA00,    0, 1);
    add("fr_fill1",    1, 32'hA04,    0, 0, 0, 0, 0, 32'hA00,    0, 2);
    add("fr_flush_redir", 1, 32'hA08, 1, 1, 1, 1, 0, 0,          0, 0);
    add("fr_push",     1, 32'hA0C,    0, 0, 0, 0, 0, 32'hA0C,    0, 1);
    add("fr_pop",      0, 0,          1, 0, 0, 0, 0, 0,          0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].rdy, vecs[i].br, vecs[i].rd,
            vecs[i].fl, vecs[i].rs);
      check_outputs(vecs[i].name, vecs[i].e_cnt, vecs[i].e_pc, vecs[i].e_ds);
    end

    drive(0, 0, 0, 0, 0, 0, 1);
    m_q.delete();
    m_ds = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic v, rdy, br, rd, fl, rs, push, pop;
      logic [31:0] pc;
      id_entry_t kept;
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      br  = !m_ds && ($urandom_range(0, 3) == 0);
      rd  = $urandom_range(0, 1) == 1;
      fl  = ($urandom_range(0, 40) == 0);
      rs  = ($urandom_range(0, 80) == 0);
      pc  = $urandom & 32'hFFFF_FFFC;
      push = v && (m_q.size() != DEPTH);
      pop  = rdy && (m_q.size() != 0);
      if (rs || fl) begin
        m_q.delete();
        m_ds = 1'b0;
      end else begin
        if (pop) begin
          void'(m_q.pop_front());
          m_ds = br;
        end
        if (pop && br && rd && m_q.size() >= 1) begin
          kept = m_q[0];
          m_q.delete();
          m_q.push_back(kept);
        end else if (push) begin
          m_q.push_back(mk(pc));
        end
      end
      drive(v, pc, rdy, br, rd, fl, rs);
      check_outputs($sformatf("rand%0d", cyc), m_q.size(),
                    (m_q.size() != 0) ? m_q[0].pc : 32'h0, m_ds);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
